// File: rtl/uart_pkg.sv
// Shared UART types and constants for the oversampled receiver and the oversample tick generator.
package uart_pkg;

  localparam int unsigned OS_RATE    = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;

  localparam int unsigned OS_W  = $clog2(OS_RATE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  // Wide enough for the largest legal OS_DIV (255)
  localparam int unsigned DIV_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Even parity holds when data bits and parity bit together have an even number of ones
  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle tick every OS_DIV clocks, with a synchronous re-phase clear.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned OS_DIV = 78
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] DivMax = DIV_W'(OS_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    tick = (div_cnt_q == DivMax);
    if (clr) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DivMax) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampled UART receiver (8N1) with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between D7 and the stop bit.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int unsigned OS_DIV = 78
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  // Input synchroniser; rxs_prev_q gives the falling-edge reference
  logic sync1_q;
  logic rxs_q;
  logic rxs_prev_q;
  logic rxs_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign rxs_fall = rxs_prev_q & ~rxs_q;

  logic tick;
  logic tick_clr;

  uart_os_tick #(
    .OS_DIV(OS_DIV)
  ) u_os_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  uart_state_e          state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 sample;
  logic                 deliver;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign sample = tick && (os_cnt_q == OS_W'(MID_SAMPLE));

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = tick ? os_cnt_q + 1'b1 : os_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    // A pending byte is released whenever the consumer accepts it
    rx_valid_d  = rx_valid_q && !rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    tick_clr    = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (rxs_fall) begin
          tick_clr = 1'b1;
          os_cnt_d = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (sample) begin
          if (!rxs_q) begin
            bit_idx_d = '0;
            state_d   = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (sample) begin
          shreg_d[bit_idx_q] = rxs_q;
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (sample) begin
          par_d   = rxs_q;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (sample) begin
          // Return to idle on the sample edge so a back-to-back start bit is not missed
          state_d = StIdle;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (!even_parity_ok(shreg_q, par_q)) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            deliver = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: directed scenarios plus randomized frames against a
// frame-level model. OS_DIV is reduced so a frame fits a short run; all timing scales with Bit.
module tb_uart_rx_os16;

  localparam int unsigned OsDiv = 8;
  localparam int unsigned Bit   = OsDiv * 16;
`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx_os16 #(
    .OS_DIV(OsDiv)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed behaviour, sampled between the stimulus negedge and the next posedge
  logic [7:0]  got_q[$];
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned fe_seen = 0, ov_seen = 0, pe_seen = 0, viol = 0;
  logic        prev_valid = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0, prev_pe = 1'b0;

  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) fe_seen++;
    if (overrun) ov_seen++;
    if (parity_err) pe_seen++;
    if ((frame_err && prev_fe) || (overrun && prev_ov) || (parity_err && prev_pe)) viol++;
    if (int'(frame_err) + int'(overrun) + int'(parity_err) > 1) viol++;
    prev_valid = rx_valid;
    prev_fe    = frame_err;
    prev_ov    = overrun;
    prev_pe    = parity_err;
  end

  // Frame-level reference: consumer-visible bytes in order, plus expected event counts
  logic [7:0]  exp_q[$];
  int unsigned exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic        mdl_full = 1'b0;
  logic [7:0]  mdl_pend = '0;
  int unsigned start_cyc = 0;

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic flip);
    if (!stop) exp_fe++;
    else if (ParEn && flip) exp_pe++;
    else if (mdl_full && !rx_ready) exp_ov++;
    else if (rx_ready) exp_q.push_back(d);
    else begin
      mdl_pend = d;
      mdl_full = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic v, input int unsigned bt);
    rxd = v;
    repeat (bt) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip,
                            input int unsigned bt);
    start_cyc = cyc;
    drive_bit(1'b0, bt);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ flip, bt);
`endif
    drive_bit(stop, bt);
  endtask

  task automatic idle(input int unsigned n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic scen_check(input string tag);
    check_eq({tag, "_bytes"}, got_q.size(), exp_q.size());
    check_eq({tag, "_frame_err"}, fe_seen, exp_fe);
    check_eq({tag, "_overrun"}, ov_seen, exp_ov);
    check_eq({tag, "_parity_err"}, pe_seen, exp_pe);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_rx_data"}, rx_data, 0);
    check_eq({tag, "_rx_valid"}, rx_valid, 0);
    check_eq({tag, "_frame_err"}, frame_err, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_parity_err"}, parity_err, 0);
  endtask

  initial begin
    int unsigned lat;
    logic [7:0]  b;
    logic [7:0]  d;
    logic        stop;
    logic        flip;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    idle(Bit);

    // Back-to-back frames; rx_valid expected 9.5 bit times (plus sync delay) after start
    send_frame(8'h55, 1'b1, 1'b0, Bit);
    lat = rise_cyc - start_cyc;
    check_eq("latency_window", (lat >= 9 * Bit + Bit / 2) && (lat <= 9 * Bit + Bit / 2 + 6), 1);
    model_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, Bit);
    model_frame(8'hA3, 1'b1, 1'b0);
    idle(Bit);
    scen_check("b2b");

    // Short low glitch (under half a bit) must be rejected silently
    rxd = 1'b0;
    repeat (Bit * 5 / 16) @(negedge clk);
    idle(2 * Bit);
    scen_check("glitch");
    send_frame(8'h3C, 1'b1, 1'b0, Bit);
    model_frame(8'h3C, 1'b1, 1'b0);
    idle(Bit);
    scen_check("after_glitch");

    // Stop bit low, then the line is held in break before recovering
    send_frame(8'h81, 1'b0, 1'b0, Bit);
    model_frame(8'h81, 1'b0, 1'b0);
    repeat (2 * Bit) @(negedge clk);
    idle(Bit);
    check_eq("ferr_no_valid", rx_valid, 0);
    scen_check("frame_err");

    // Consumer stalled: first byte held, second dropped as overrun
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, Bit);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, Bit);
    model_frame(8'h22, 1'b1, 1'b0);
    idle(Bit);
    check_eq("ovr_valid_held", rx_valid, 1);
    check_eq("ovr_data_held", rx_data, 8'h11);
    scen_check("overrun");
    rx_ready = 1'b1;
    exp_q.push_back(mdl_pend);
    mdl_full = 1'b0;
    @(negedge clk);
    rx_ready = 1'b0;
    check_eq("accept_clears", rx_valid, 0);

    // Reset in the middle of D4 with a byte pending; both are lost
    send_frame(8'h5A, 1'b1, 1'b0, Bit);
    model_frame(8'h5A, 1'b1, 1'b0);
    idle(Bit);
    check_eq("pend_valid", rx_valid, 1);
    b = 8'hF0;
    drive_bit(1'b0, Bit);
    for (int i = 0; i < 4; i++) drive_bit(b[i], Bit);
    rxd = b[4];
    repeat (Bit / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_full = 1'b0;
    check_zero("midframe_rst");
    idle(Bit / 2 + 4 * Bit);
    rx_ready = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b0, Bit);
    model_frame(8'h0F, 1'b1, 1'b0);
    idle(Bit);
    scen_check("after_rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, Bit);
    model_frame(8'h07, 1'b1, 1'b1);
    idle(Bit);
    send_frame(8'h07, 1'b1, 1'b0, Bit);
    model_frame(8'h07, 1'b1, 1'b0);
    idle(Bit);
    scen_check("parity");
`endif

    // Random bytes, bit-time jitter, occasional bad stop (and bad parity when enabled)
    for (int n = 0; n < 25; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      flip = ($urandom_range(0, 5) == 0);
      send_frame(d, stop, flip, Bit - 2 + $urandom_range(0, 4));
      model_frame(d, stop, flip);
      idle(stop ? $urandom_range(0, Bit) : $urandom_range(4, Bit / 2));
    end
    idle(Bit);
    scen_check("random");

    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_eq($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    end
    check_eq("pulse_shape", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
